axi_cache_port_mux: RTL

- Parametrised N-master to 1-slave AXI4 multiplexer for the L1 cache subsystem. It merges the I$, D$ refill, D$ bypass and any future ports (PTW, accelerator) onto the single ariane_axi master port.
- It replaces fixed-ID response routing with master-index ID prefixing, and adds per-master outstanding-transaction tracking.
- It adds a bounded W-ordering queue with AW back-pressure, a selectable arbitration policy, and a quiesce/idle handshake used before fence.i and flush.

---
 rtl/axi_cache_port_mux_pkg.sv | 102 ++++++++++
 rtl/axi_lock_arbiter.sv | 60 ++++++
 rtl/axi_cache_port_mux.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/axi_cache_port_mux_pkg.sv
// Shared types for the L1 cache AXI port multiplexer.
// Holds the default widths, the master-index and outstanding-counter types,
// and the request/response structs used on the master and slave sides.
package axi_cache_port_mux_pkg;

    localparam int unsigned NUM_MST  = 3;
    localparam int unsigned MST_ID_W = 4;
    localparam int unsigned SEL_W    = $clog2(NUM_MST);
    localparam int unsigned SLV_ID_W = MST_ID_W + SEL_W;
    localparam int unsigned MAX_TXN  = 4;
    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 64;
    localparam int unsigned STRB_W   = DATA_W / 8;

    typedef logic [SEL_W-1:0]              mst_idx_t;
    typedef logic [$clog2(MAX_TXN+1)-1:0]  txn_cnt_t;

    typedef struct packed {
        logic [MST_ID_W-1:0] id;
        logic [ADDR_W-1:0]   addr;
        logic [7:0]          len;
    } mst_ax_t;

    typedef struct packed {
        logic [SLV_ID_W-1:0] id;
        logic [ADDR_W-1:0]   addr;
        logic [7:0]          len;
    } slv_ax_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
        logic              last;
    } w_chan_t;

    typedef struct packed {
        logic [MST_ID_W-1:0] id;
        logic [DATA_W-1:0]   data;
        logic [1:0]          resp;
        logic                last;
    } mst_r_t;

    typedef struct packed {
        logic [SLV_ID_W-1:0] id;
        logic [DATA_W-1:0]   data;
        logic [1:0]          resp;
        logic                last;
    } slv_r_t;

    typedef struct packed {
        logic [MST_ID_W-1:0] id;
        logic [1:0]          resp;
    } mst_b_t;

    typedef struct packed {
        logic [SLV_ID_W-1:0] id;
        logic [1:0]          resp;
    } slv_b_t;

    typedef struct packed {
        mst_ax_t aw;
        logic    aw_valid;
        w_chan_t w;
        logic    w_valid;
        logic    b_ready;
        mst_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } mst_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        logic   b_valid;
        mst_b_t b;
        logic   r_valid;
        mst_r_t r;
    } mst_resp_t;

    typedef struct packed {
        slv_ax_t aw;
        logic    aw_valid;
        w_chan_t w;
        logic    w_valid;
        logic    b_ready;
        slv_ax_t ar;
        logic    ar_valid;
        logic    r_ready;
    } slv_req_t;

    typedef struct packed {
        logic   aw_ready;
        logic   ar_ready;
        logic   w_ready;
        logic   b_valid;
        slv_b_t b;
        logic   r_valid;
        slv_r_t r;
    } slv_resp_t;

endpackage

// File: rtl/axi_lock_arbiter.sv
// N-input valid/ready arbiter with grant lock.
// Ports: clk/rst (sync, active-high), req = per-input eligibility,
// ready = downstream ready, valid/idx = granted request, locked = grant held
// from a previous cycle while waiting for ready.
// Once a grant is presented without ready it is frozen until the handshake,
// regardless of what happens to req, so downstream valid never drops.
module axi_lock_arbiter #(
    parameter int unsigned N          = 3,
    parameter bit          RoundRobin = 1'b1,
    parameter int unsigned IdxW       = $clog2(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic            ready,
    output logic            valid,
    output logic [IdxW-1:0] idx,
    output logic            locked
);

    logic [IdxW-1:0] ptr;
    logic [IdxW-1:0] lock_idx;
    logic            lock_q;
    logic [IdxW-1:0] pick;
    logic            found;
    int              cand;

    // Scan starts at the RR pointer (or at 0 for fixed priority).
    always_comb begin
        pick  = '0;
        found = 1'b0;
        cand  = 0;
        for (int k = 0; k < int'(N); k++) begin
            cand = RoundRobin ? (int'(ptr) + k) % int'(N) : k;
            if (!found && req[cand]) begin
                pick  = IdxW'(cand);
                found = 1'b1;
            end
        end
    end

    assign valid  = lock_q | found;
    assign idx    = lock_q ? lock_idx : pick;
    assign locked = lock_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= '0;
            lock_q   <= 1'b0;
            lock_idx <= '0;
        end else if (valid && ready) begin
            lock_q <= 1'b0;
            ptr    <= IdxW'((int'(idx) + 1) % int'(N));
        end else if (valid) begin
            lock_q   <= 1'b1;
            lock_idx <= idx;
        end
    end

endmodule

// File: rtl/axi_cache_port_mux.sv
// N-master to 1-slave AXI4 multiplexer for the L1 cache ports.
// Ports: clk_i/rst_i (sync, active-high); mst_req_i/mst_resp_o per cache port;
// slv_req_o/slv_resp_i toward memory; quiesce_i blocks new AR/AW grants;
// idle_o = quiesced with nothing in flight; busy_o = per-master outstanding;
// err_o = one-cycle pulse after an R/B beat whose ID names no master.
// Slave IDs carry the master index in their top SelW bits so responses route
// back without any lookup table.
module axi_cache_port_mux
    import axi_cache_port_mux_pkg::*;
#(
    parameter int unsigned NumMst     = 3,
    parameter int unsigned MstIdWidth = 4,
    parameter int unsigned SelW       = $clog2(NumMst),
    parameter int unsigned SlvIdWidth = MstIdWidth + SelW,
    parameter int unsigned MaxTxn     = 4,
    parameter int unsigned WFifoDepth = 4,
    parameter bit          RoundRobin = 1'b1,
    parameter type mst_req_t  = axi_cache_port_mux_pkg::mst_req_t,
    parameter type mst_resp_t = axi_cache_port_mux_pkg::mst_resp_t,
    parameter type slv_req_t  = axi_cache_port_mux_pkg::slv_req_t,
    parameter type slv_resp_t = axi_cache_port_mux_pkg::slv_resp_t
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  mst_req_t          mst_req_i  [NumMst],
    output mst_resp_t         mst_resp_o [NumMst],
    output slv_req_t          slv_req_o,
    input  slv_resp_t         slv_resp_i,
    input  logic              quiesce_i,
    output logic              idle_o,
    output logic [NumMst-1:0] busy_o,
    output logic              err_o
);

    localparam int unsigned CntW  = $clog2(MaxTxn + 1);
    localparam int unsigned QPtrW = (WFifoDepth > 1) ? $clog2(WFifoDepth) : 1;
    localparam int unsigned QCntW = $clog2(WFifoDepth + 1);

    typedef logic [SelW-1:0] sel_t;
    typedef logic [CntW-1:0] cnt_t;

    cnt_t              rd_cnt [NumMst];
    cnt_t              wr_cnt [NumMst];
    logic [NumMst-1:0] ar_elig, aw_elig;
    logic [NumMst-1:0] rd_inc, rd_dec, wr_inc, wr_dec;
    logic              ar_valid, aw_valid, ar_locked, aw_locked;
    sel_t              ar_sel, aw_sel;

    sel_t              wq_mem [WFifoDepth];
    logic [QPtrW-1:0]  wq_wr, wq_rd;
    logic [QCntW-1:0]  wq_cnt;
    logic              wq_empty, wq_full, wq_push, wq_pop;
    sel_t              w_sel;

    sel_t              r_sel, b_sel;
    logic              r_bad, b_bad;
    logic              err_q;

    function automatic logic [QPtrW-1:0] ptr_inc(input logic [QPtrW-1:0] p);
        return (p == QPtrW'(WFifoDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign wq_empty = (wq_cnt == '0);
    assign wq_full  = (wq_cnt == QCntW'(WFifoDepth));
    assign w_sel    = wq_mem[wq_rd];

    assign r_sel = slv_resp_i.r.id[SlvIdWidth-1 -: SelW];
    assign b_sel = slv_resp_i.b.id[SlvIdWidth-1 -: SelW];
    assign r_bad = int'(r_sel) >= int'(NumMst);
    assign b_bad = int'(b_sel) >= int'(NumMst);

    // Quiesce only gates fresh grants; a locked grant is held by the arbiter.
    always_comb begin
        ar_elig = '0;
        aw_elig = '0;
        for (int i = 0; i < int'(NumMst); i++) begin
            ar_elig[i] = mst_req_i[i].ar_valid && (rd_cnt[i] < CntW'(MaxTxn)) && !quiesce_i;
            aw_elig[i] = mst_req_i[i].aw_valid && (wr_cnt[i] < CntW'(MaxTxn)) && !wq_full
                         && !quiesce_i;
        end
    end

    axi_lock_arbiter #(.N(NumMst), .RoundRobin(RoundRobin), .IdxW(SelW)) u_ar_arb (
        .clk    (clk_i),
        .rst    (rst_i),
        .req    (ar_elig),
        .ready  (slv_resp_i.ar_ready),
        .valid  (ar_valid),
        .idx    (ar_sel),
        .locked (ar_locked)
    );

    axi_lock_arbiter #(.N(NumMst), .RoundRobin(RoundRobin), .IdxW(SelW)) u_aw_arb (
        .clk    (clk_i),
        .rst    (rst_i),
        .req    (aw_elig),
        .ready  (slv_resp_i.aw_ready),
        .valid  (aw_valid),
        .idx    (aw_sel),
        .locked (aw_locked)
    );

    // Channel muxing and response demux. Unroutable R/B beats are sunk.
    always_comb begin
        slv_req_o          = '0;
        slv_req_o.ar_valid = ar_valid;
        slv_req_o.aw_valid = aw_valid;
        slv_req_o.r_ready  = r_bad;
        slv_req_o.b_ready  = b_bad;
        for (int i = 0; i < int'(NumMst); i++) begin
            mst_resp_o[i] = '0;
            if (ar_sel == sel_t'(i)) begin
                slv_req_o.ar.id        = {ar_sel, mst_req_i[i].ar.id};
                slv_req_o.ar.addr      = mst_req_i[i].ar.addr;
                slv_req_o.ar.len       = mst_req_i[i].ar.len;
                mst_resp_o[i].ar_ready = ar_valid && slv_resp_i.ar_ready;
            end
            if (aw_sel == sel_t'(i)) begin
                slv_req_o.aw.id        = {aw_sel, mst_req_i[i].aw.id};
                slv_req_o.aw.addr      = mst_req_i[i].aw.addr;
                slv_req_o.aw.len       = mst_req_i[i].aw.len;
                mst_resp_o[i].aw_ready = aw_valid && slv_resp_i.aw_ready;
            end
            if (!wq_empty && (w_sel == sel_t'(i))) begin
                slv_req_o.w           = mst_req_i[i].w;
                slv_req_o.w_valid     = mst_req_i[i].w_valid;
                mst_resp_o[i].w_ready = slv_resp_i.w_ready;
            end
            if (!r_bad && (r_sel == sel_t'(i))) begin
                mst_resp_o[i].r_valid = slv_resp_i.r_valid;
                mst_resp_o[i].r.id    = slv_resp_i.r.id[MstIdWidth-1:0];
                mst_resp_o[i].r.data  = slv_resp_i.r.data;
                mst_resp_o[i].r.resp  = slv_resp_i.r.resp;
                mst_resp_o[i].r.last  = slv_resp_i.r.last;
                slv_req_o.r_ready     = mst_req_i[i].r_ready;
            end
            if (!b_bad && (b_sel == sel_t'(i))) begin
                mst_resp_o[i].b_valid = slv_resp_i.b_valid;
                mst_resp_o[i].b.id    = slv_resp_i.b.id[MstIdWidth-1:0];
                mst_resp_o[i].b.resp  = slv_resp_i.b.resp;
                slv_req_o.b_ready     = mst_req_i[i].b_ready;
            end
        end
    end

    assign wq_push = aw_valid && slv_resp_i.aw_ready;
    assign wq_pop  = slv_req_o.w_valid && slv_resp_i.w_ready && slv_req_o.w.last;

    always_comb begin
        rd_inc = '0;
        rd_dec = '0;
        wr_inc = '0;
        wr_dec = '0;
        for (int i = 0; i < int'(NumMst); i++) begin
            rd_inc[i] = ar_valid && slv_resp_i.ar_ready && (ar_sel == sel_t'(i));
            rd_dec[i] = mst_resp_o[i].r_valid && mst_req_i[i].r_ready && slv_resp_i.r.last;
            wr_inc[i] = wq_push && (aw_sel == sel_t'(i));
            wr_dec[i] = mst_resp_o[i].b_valid && mst_req_i[i].b_ready;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(NumMst); i++) begin
                rd_cnt[i] <= '0;
                wr_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NumMst); i++) begin
                assert (!(rd_dec[i] && !rd_inc[i] && (rd_cnt[i] == '0)));
                assert (!(wr_dec[i] && !wr_inc[i] && (wr_cnt[i] == '0)));
                if (rd_inc[i] && !rd_dec[i])      rd_cnt[i] <= rd_cnt[i] + 1'b1;
                else if (!rd_inc[i] && rd_dec[i]) rd_cnt[i] <= rd_cnt[i] - 1'b1;
                if (wr_inc[i] && !wr_dec[i])      wr_cnt[i] <= wr_cnt[i] + 1'b1;
                else if (!wr_inc[i] && wr_dec[i]) wr_cnt[i] <= wr_cnt[i] - 1'b1;
            end
        end
    end

    // W ordering queue: entries become visible the cycle after the AW push.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wq_wr  <= '0;
            wq_rd  <= '0;
            wq_cnt <= '0;
        end else begin
            if (wq_push) wq_wr <= ptr_inc(wq_wr);
            if (wq_pop)  wq_rd <= ptr_inc(wq_rd);
            if (wq_push && !wq_pop)      wq_cnt <= wq_cnt + 1'b1;
            else if (!wq_push && wq_pop) wq_cnt <= wq_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wq_push) wq_mem[wq_wr] <= aw_sel;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) err_q <= 1'b0;
        else       err_q <= (slv_resp_i.r_valid && r_bad) || (slv_resp_i.b_valid && b_bad);
    end

    assign err_o = err_q;

    always_comb begin
        idle_o = quiesce_i && !ar_locked && !aw_locked && wq_empty;
        busy_o = '0;
        for (int i = 0; i < int'(NumMst); i++) begin
            busy_o[i] = (rd_cnt[i] != '0) || (wr_cnt[i] != '0);
            if (busy_o[i]) idle_o = 1'b0;
        end
    end

endmodule
